// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage MIPS pipeline; all hazard outputs are combinational (zero latency).
// Saturating stall counters are built only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0 and Clk/Rst_n are unused.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemToRegE,
  input  logic             MemToRegM,
  input  logic             BranchD,
  input  logic             JumpD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] BrStallCnt
);

  logic lwStall;
  logic brStall;
  logic stall;

  // Every output defaults to 0 and is raised only by a true condition, so unknown inputs fall through to 0.
  always_comb begin
    ForwardAE = 2'b00;
    if (RsE != 5'd0 && RegWriteM && RsE == WriteRegM)      ForwardAE = 2'b10;
    else if (RsE != 5'd0 && RegWriteW && RsE == WriteRegW) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RtE != 5'd0 && RegWriteM && RtE == WriteRegM)      ForwardBE = 2'b10;
    else if (RtE != 5'd0 && RegWriteW && RtE == WriteRegW) ForwardBE = 2'b01;

    ForwardAD = 1'b0;
    if (RsD != 5'd0 && RegWriteM && RsD == WriteRegM) ForwardAD = 1'b1;

    ForwardBD = 1'b0;
    if (RtD != 5'd0 && RegWriteM && RtD == WriteRegM) ForwardBD = 1'b1;

    lwStall = 1'b0;
    if (MemToRegE && RtE != 5'd0 && (RsD == RtE || RtD == RtE)) lwStall = 1'b1;

    // Jumps only read RsD; branches compare both operands in Decode.
    brStall = 1'b0;
    if ((BranchD || JumpD) &&
        ((RegWriteE && WriteRegE != 5'd0 &&
          (WriteRegE == RsD || (BranchD && WriteRegE == RtD))) ||
         (MemToRegM && WriteRegM != 5'd0 &&
          (WriteRegM == RsD || (BranchD && WriteRegM == RtD)))))
      brStall = 1'b1;

    stall = 1'b0;
    if (lwStall || brStall) stall = 1'b1;
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      StallCnt   <= '0;
      BrStallCnt <= '0;
    end else begin
      if (stall && StallCnt != CNT_MAX)     StallCnt   <= StallCnt + CNT_W'(1);
      if (brStall && BrStallCnt != CNT_MAX) BrStallCnt <= BrStallCnt + CNT_W'(1);
    end
  end
`else
  logic unusedClkRst;
  assign unusedClkRst = Clk ^ Rst_n;
  assign StallCnt     = '0;
  assign BrStallCnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a rule-level reference model.
module tb_hazard_unit;
  logic        Clk, Rst_n;
  logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemToRegE, MemToRegM, BranchD, JumpD;
  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCnt, BrStallCnt;

  int checks = 0;
  int errors = 0;
  int refStall = 0;
  int refBr = 0;

  hazard_unit #(.CNT_W(16)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemToRegE(MemToRegE), .MemToRegM(MemToRegM), .BranchD(BranchD), .JumpD(JumpD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCnt(StallCnt), .BrStallCnt(BrStallCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: which pipeline stage (if any) holds the newest value of a register.
  function automatic logic [1:0] refFwdE(input logic [4:0] src);
    if (src == 5'd0) return 2'b00;
    if (RegWriteM && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic refFwdD(input logic [4:0] src);
    return (src != 5'd0) && RegWriteM && (WriteRegM == src);
  endfunction

  function automatic logic refLw();
    if (!MemToRegE || RtE == 5'd0) return 1'b0;
    return (RsD == RtE) || (RtD == RtE);
  endfunction

  function automatic logic refBrStall();
    logic [4:0] readers[$];
    logic [4:0] pending[$];
    if (BranchD || JumpD) readers.push_back(RsD);
    if (BranchD) readers.push_back(RtD);
    if (RegWriteE) pending.push_back(WriteRegE);
    if (MemToRegM) pending.push_back(WriteRegM);
    foreach (pending[p])
      foreach (readers[r])
        if (pending[p] != 5'd0 && pending[p] == readers[r]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clearIns();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemToRegE = 0; MemToRegM = 0;
    BranchD = 0; JumpD = 0;
  endtask

  task automatic checkComb(input string tag);
    logic st;
    #1;
    st = refLw() | refBrStall();
    chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(refFwdE(RsE)));
    chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(refFwdE(RtE)));
    chk({tag, ".ForwardAD"}, 32'(ForwardAD), 32'(refFwdD(RsD)));
    chk({tag, ".ForwardBD"}, 32'(ForwardBD), 32'(refFwdD(RtD)));
    chk({tag, ".StallF"}, 32'(StallF), 32'(st));
    chk({tag, ".StallD"}, 32'(StallD), 32'(st));
    chk({tag, ".FlushE"}, 32'(FlushE), 32'(st));
  endtask

  task automatic endCycle(input string tag);
    logic lw, br;
    lw = refLw();
    br = refBrStall();
    @(posedge Clk);
`ifdef HAZARD_PERF_CNT_EN
    if (lw || br) refStall = (refStall < 65535) ? refStall + 1 : 65535;
    if (br) refBr = (refBr < 65535) ? refBr + 1 : 65535;
`endif
    #1;
    chk({tag, ".StallCnt"}, 32'(StallCnt), 32'(refStall));
    chk({tag, ".BrStallCnt"}, 32'(BrStallCnt), 32'(refBr));
  endtask

  initial begin
    clearIns();
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #1;
    chk("reset.StallCnt", 32'(StallCnt), 0);
    chk("reset.BrStallCnt", 32'(BrStallCnt), 0);
    checkComb("reset.zero");
    chk("reset.StallF", 32'(StallF), 0);
    @(posedge Clk); #1 Rst_n = 1'b1;

    // Forwarding: M beats W, then W alone
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    checkComb("t1a"); chk("t1a.AE10", 32'(ForwardAE), 2); endCycle("t1a");
    RegWriteM = 0;
    checkComb("t1b"); chk("t1b.AE01", 32'(ForwardAE), 1); endCycle("t1b");

    // $0 never forwarded
    clearIns(); RtE = 0; WriteRegM = 0; RegWriteM = 1; RsD = 0; BranchD = 1;
    checkComb("t2"); chk("t2.BE00", 32'(ForwardBE), 0); chk("t2.AD0", 32'(ForwardAD), 0);
    endCycle("t2");

    // Load-use
    clearIns(); MemToRegE = 1; RtE = 8; RsD = 8;
    checkComb("t3a"); chk("t3a.stall", 32'({StallF, StallD, FlushE}), 7); endCycle("t3a");
    RtE = 9;
    checkComb("t3b"); chk("t3b.stall", 32'({StallF, StallD, FlushE}), 0); endCycle("t3b");

    // Branch compare dependencies
    clearIns(); BranchD = 1; RtD = 3; RegWriteE = 1; WriteRegE = 3;
    checkComb("t4a"); chk("t4a.stall", 32'(StallF), 1); endCycle("t4a");
    MemToRegM = 1; WriteRegM = 3; RegWriteE = 0;
    checkComb("t4b"); chk("t4b.stall", 32'(StallF), 1); endCycle("t4b");
    MemToRegM = 0; RegWriteM = 1;
    checkComb("t4c"); chk("t4c.stall", 32'(StallF), 0); chk("t4c.BD", 32'(ForwardBD), 1);
    endCycle("t4c");

    // Jump checks RsD only
    clearIns(); JumpD = 1; RsD = 31; WriteRegE = 31; RegWriteE = 1;
    checkComb("t5a"); chk("t5a.stall", 32'(StallF), 1); endCycle("t5a");
    RtD = 31; RsD = 0;
    checkComb("t5b"); chk("t5b.stall", 32'(StallF), 0); endCycle("t5b");

    // Counters: 4 load stalls then 2 branch stalls from a fresh reset
    clearIns();
    Rst_n = 1'b0; #1;
    chk("t6.rst.StallCnt", 32'(StallCnt), 0);
    chk("t6.rst.BrStallCnt", 32'(BrStallCnt), 0);
    refStall = 0; refBr = 0;
    Rst_n = 1'b1; #1;
    MemToRegE = 1; RtE = 8; RsD = 8;
    for (int i = 0; i < 4; i++) begin checkComb("t6.lw"); endCycle("t6.lw"); end
    clearIns(); BranchD = 1; RtD = 3; RegWriteE = 1; WriteRegE = 3;
    for (int i = 0; i < 2; i++) begin checkComb("t6.br"); endCycle("t6.br"); end
`ifdef HAZARD_PERF_CNT_EN
    chk("t6.StallCnt6", 32'(StallCnt), 6);
    chk("t6.BrStallCnt2", 32'(BrStallCnt), 2);
`else
    chk("t6.StallCntTied", 32'(StallCnt), 0);
    chk("t6.BrStallCntTied", 32'(BrStallCnt), 0);
`endif

    // Reset while stalled: counters clear at once, stall outputs stay
    Rst_n = 1'b0; #1;
    chk("t6.midrst.StallCnt", 32'(StallCnt), 0);
    chk("t6.midrst.BrStallCnt", 32'(BrStallCnt), 0);
    chk("t6.midrst.StallF", 32'(StallF), 1);
    chk("t6.midrst.FlushE", 32'(FlushE), 1);
    refStall = 0; refBr = 0;
    Rst_n = 1'b1;
    checkComb("t6.post"); endCycle("t6.post");

`ifdef HAZARD_PERF_CNT_EN
    clearIns(); MemToRegE = 1; RtE = 8; RsD = 8;
    repeat (65539) @(posedge Clk);
    #1;
    chk("t6.sat.StallCnt", 32'(StallCnt), 32'hFFFF);
    chk("t6.sat.BrStallCnt", 32'(BrStallCnt), 32'(refBr));
    refStall = 65535;
`endif

    // Randomized: small register range to force frequent collisions
    for (int n = 0; n < 400; n++) begin
      RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
      RsE = 5'($urandom_range(0, 3)); RtE = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1)); MemToRegE = 1'($urandom_range(0, 1));
      MemToRegM = 1'($urandom_range(0, 1)); BranchD = 1'($urandom_range(0, 1));
      JumpD = 1'($urandom_range(0, 1));
      checkComb("rand");
      endCycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
